mvm_program_seq: RTL and testbench
==================================

MVM_PROGRAM_SEQ -- requirements
Module: mvm_program_seq

Interface
REQ-001 Parameter DATAW, default 512: NoC payload width, in bits.
REQ-002 Parameter DESTW, default 12: router destination width.
REQ-003 Parameter NUM_ROWS, default 64: register-file rows per MVM tile.
REQ-004 Parameter RF_ADDRW, default 9: register-file address width.
REQ-005 Parameter USERW, default 11+NUM_ROWS: NoC tuser width.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, named as follows:
- CLK in 1: the single clock.
- RST in 1: asynchronous, active-high reset.
REQ-007 Command ports SHALL be:
- START in 1: pulse that starts a program.
- CFG_DEST in DESTW: target router.
- CFG_RF_ADDR in RF_ADDRW: register-file address.
- CFG_ACCUM_ADDR in 9: accumulator address.
- CFG_RLS_DEST in 9: release destination.
- CFG_ACCUM in 1: accumulate-enable bit.
REQ-008 Host stream ports SHALL be:
- HOST_TVALID in 1.
- HOST_TREADY out 1.
- HOST_TDATA in DATAW: NUM_ROWS weight rows, then one input vector.
REQ-009 NoC master ports SHALL be:
- AXIS_M_TVALID out 1.
- AXIS_M_TREADY in 1.
- AXIS_M_TDATA out DATAW.
- AXIS_M_TDEST out DESTW.
- AXIS_M_TUSER out USERW.
- AXIS_M_TLAST out 1.
REQ-010 NoC result ports SHALL be:
- AXIS_R_TVALID in 1.
- AXIS_R_TREADY out 1.
- AXIS_R_TDATA in DATAW.
REQ-011 Status ports SHALL be:
- BUSY out 1.
- DONE out 1: one-cycle pulse.
- ERR out 1: sticky.
- RESULT out DATAW: last captured result.

Function
REQ-012 The FSM SHALL have states IDLE, WEIGHTS, VECTOR, INSTR, WAIT_RES; BUSY=1 in every state except IDLE.
REQ-013 In IDLE, START SHALL latch all CFG_* inputs, clear the row counter, and enter WEIGHTS on the next cycle; START is ignored outside IDLE.
REQ-014 In WEIGHTS, HOST_TREADY SHALL equal AXIS_M_TREADY or !AXIS_M_TVALID (skid-free pass-through via one output register); each accepted word SHALL emit one beat with:
- tuser[8:0] = RF address.
- tuser[10:9] = 2'b11.
- tuser[11+row] = 1 (one-hot), all other row bits 0.
- TLAST = 1.
REQ-015 The row counter SHALL increment on each accepted weight word; after row NUM_ROWS-1 the FSM SHALL enter VECTOR (no wrap).
REQ-016 In VECTOR, one host word SHALL be forwarded with tuser[10:9] = 2'b10, all other tuser bits 0, and TLAST = 1, then the FSM SHALL enter INSTR.
REQ-017 In INSTR, HOST_TREADY SHALL be 0 and one beat SHALL be emitted with:
- tdata[0] = 0 (RDC).
- tdata[1] = CFG_ACCUM.
- tdata[2] = 1 (RLS).
- tdata[3] = 1 (LST).
- tdata[12:4] = accumulator address.
- tdata[21:13] = RF address.
- tdata[30:22] = release destination.
- tdata[31] = 1 (RLS_OP).
- All other tdata bits 0; tuser = 0; TLAST = 1.
REQ-018 After the instruction beat is accepted, the FSM SHALL enter WAIT_RES.
REQ-019 AXIS_R_TREADY SHALL be 1 only in WAIT_RES; the first accepted result SHALL be registered into RESULT, DONE SHALL pulse on the following cycle, and the FSM SHALL return to IDLE.
REQ-020 AXIS_M_TVALID SHALL hold with stable TDATA/TDEST/TUSER/TLAST until AXIS_M_TREADY; backpressure of any length SHALL NOT drop or duplicate beats.
REQ-021 AXIS_M_TDEST SHALL equal the latched CFG_DEST for every beat of a program.
REQ-022 Latency SHALL be: START to first AXIS_M_TVALID = 2 cycles given HOST_TVALID held high; accepted result to DONE = 1 cycle.
REQ-023 Results arriving outside WAIT_RES SHALL NOT be accepted (TREADY=0).

Reset
REQ-024 RST SHALL asynchronously set:
- FSM = IDLE.
- Row counter = 0.
- Outputs: AXIS_M_TVALID=0, HOST_TREADY=0, AXIS_R_TREADY=0, BUSY=0, DONE=0, ERR=0, RESULT=0, and all AXIS_M data/user/dest/last = 0.
REQ-025 Reset mid-program SHALL abandon the program; no further beats SHALL be emitted until a new START.

Configuration
REQ-026 With SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_RES; reaching parameter TIMEOUT_CYC (default 4096) SHALL set ERR, pulse DONE, and return to IDLE with RESULT unchanged.
REQ-027 Without SEQ_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely and ERR SHALL be tied to 0.

Verification
REQ-028 NUM_ROWS=4, CFG_DEST=12'h001, CFG_RF_ADDR=9'h1, 5 host words -> 4 beats with tuser[10:9]=11 and one-hot bits 11,12,13,14; then a vector beat with tuser=0x400; then an instruction beat with tdata[31:0]=0x80C0201E.
REQ-029 Random AXIS_M_TREADY at 30% duty -> beat sequence identical to REQ-028 with no drops or duplicates.
REQ-030 Result 0xABCD injected in WAIT_RES -> RESULT=0xABCD and a DONE pulse one cycle later; a result injected in IDLE -> not accepted.
REQ-031 RST asserted during row 2 of WEIGHTS -> all outputs 0 immediately; a new START replays from row 0.
REQ-032 SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=100, no result -> ERR=1 and DONE pulse at cycle 100 of WAIT_RES.

Source files
------------

// File: rtl/mvm_program_seq.sv
// mvm_program_seq: streams NUM_ROWS weight rows, one input vector and one
// release instruction to an MVM tile over the NoC, then waits for the result.
// Optional build macro SEQ_TIMEOUT_EN: bounds WAIT_RES by TIMEOUT_CYC cycles
// and reports expiry on a sticky ERR.
module mvm_program_seq #(
  parameter int DATAW       = 512,
  parameter int DESTW       = 12,
  parameter int NUM_ROWS    = 64,
  parameter int RF_ADDRW    = 9,
  parameter int USERW       = 11 + NUM_ROWS
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [DESTW-1:0]    CFG_DEST,
  input  logic [RF_ADDRW-1:0] CFG_RF_ADDR,
  input  logic [8:0]          CFG_ACCUM_ADDR,
  input  logic [8:0]          CFG_RLS_DEST,
  input  logic                CFG_ACCUM,
  input  logic                HOST_TVALID,
  output logic                HOST_TREADY,
  input  logic [DATAW-1:0]    HOST_TDATA,
  output logic                AXIS_M_TVALID,
  input  logic                AXIS_M_TREADY,
  output logic [DATAW-1:0]    AXIS_M_TDATA,
  output logic [DESTW-1:0]    AXIS_M_TDEST,
  output logic [USERW-1:0]    AXIS_M_TUSER,
  output logic                AXIS_M_TLAST,
  input  logic                AXIS_R_TVALID,
  output logic                AXIS_R_TREADY,
  input  logic [DATAW-1:0]    AXIS_R_TDATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [DATAW-1:0]    RESULT
);
  localparam int ROWW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(NUM_ROWS - 1);

  typedef enum logic [2:0] {IDLE, WEIGHTS, VECTOR, INSTR, WAIT_RES} state_t;

  state_t                state_q, state_d;
  logic [ROWW-1:0]       row_q, row_d;
  logic [DESTW-1:0]      dest_q, dest_d;
  logic [RF_ADDRW-1:0]   rf_q, rf_d;
  logic [8:0]            acc_addr_q, acc_addr_d;
  logic [8:0]            rls_q, rls_d;
  logic                  accum_q, accum_d;
  logic                  mv_q, mv_d;
  logic [DATAW-1:0]      md_q, md_d;
  logic [USERW-1:0]      mu_q, mu_d;
  logic                  ml_q, ml_d;
  logic                  sent_q, sent_d;
  logic                  done_q, done_d;
  logic [DATAW-1:0]      res_q, res_d;
  logic                  out_ready;
  logic                  host_rdy;
  logic                  r_rdy;

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // Output register may take a new beat when empty or draining this cycle.
  assign out_ready = !mv_q || AXIS_M_TREADY;

  // Next-state, output-register loading and handshake generation.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    dest_d     = dest_q;
    rf_d       = rf_q;
    acc_addr_d = acc_addr_q;
    rls_d      = rls_q;
    accum_d    = accum_q;
    mv_d       = mv_q;
    md_d       = md_q;
    mu_d       = mu_q;
    ml_d       = ml_q;
    sent_d     = sent_q;
    done_d     = 1'b0;
    res_d      = res_q;
    host_rdy   = 1'b0;
    r_rdy      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d      = 16'd0;
    err_d      = err_q;
`endif
    if (mv_q && AXIS_M_TREADY) mv_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          dest_d     = CFG_DEST;
          rf_d       = CFG_RF_ADDR;
          acc_addr_d = CFG_ACCUM_ADDR;
          rls_d      = CFG_RLS_DEST;
          accum_d    = CFG_ACCUM;
          row_d      = '0;
          sent_d     = 1'b0;
          state_d    = WEIGHTS;
        end
      end
      WEIGHTS: begin
        host_rdy = out_ready;
        if (HOST_TVALID && out_ready) begin
          mv_d = 1'b1;
          md_d = HOST_TDATA;
          mu_d = (USERW'(1) << (11 + int'(row_q))) | USERW'({2'b11, 9'(rf_q)});
          ml_d = 1'b1;
          if (row_q == LAST_ROW) state_d = VECTOR;
          else                   row_d   = row_q + 1'b1;
        end
      end
      VECTOR: begin
        host_rdy = out_ready;
        if (HOST_TVALID && out_ready) begin
          mv_d    = 1'b1;
          md_d    = HOST_TDATA;
          mu_d    = USERW'(1) << 10;
          ml_d    = 1'b1;
          sent_d  = 1'b0;
          state_d = INSTR;
        end
      end
      INSTR: begin
        // Load the instruction once, then leave only when the tile takes it.
        if (!sent_q) begin
          if (out_ready) begin
            mv_d        = 1'b1;
            md_d        = '0;
            md_d[31:0]  = {1'b1, rls_q, 9'(rf_q), acc_addr_q, 1'b1, 1'b1, accum_q, 1'b0};
            mu_d        = '0;
            ml_d        = 1'b1;
            sent_d      = 1'b1;
          end
        end else if (AXIS_M_TREADY) begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        r_rdy = 1'b1;
        if (AXIS_R_TVALID) begin
          res_d   = AXIS_R_TDATA;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any program in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      row_q      <= '0;
      dest_q     <= '0;
      rf_q       <= '0;
      acc_addr_q <= '0;
      rls_q      <= '0;
      accum_q    <= 1'b0;
      mv_q       <= 1'b0;
      md_q       <= '0;
      mu_q       <= '0;
      ml_q       <= 1'b0;
      sent_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      dest_q     <= dest_d;
      rf_q       <= rf_d;
      acc_addr_q <= acc_addr_d;
      rls_q      <= rls_d;
      accum_q    <= accum_d;
      mv_q       <= mv_d;
      md_q       <= md_d;
      mu_q       <= mu_d;
      ml_q       <= ml_d;
      sent_q     <= sent_d;
      done_q     <= done_d;
      res_q      <= res_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign HOST_TREADY   = host_rdy;
  assign AXIS_R_TREADY = r_rdy;
  assign AXIS_M_TVALID = mv_q;
  assign AXIS_M_TDATA  = md_q;
  assign AXIS_M_TDEST  = dest_q;
  assign AXIS_M_TUSER  = mu_q;
  assign AXIS_M_TLAST  = ml_q;
  assign BUSY          = (state_q != IDLE);
  assign DONE          = done_q;
  assign RESULT        = res_q;
`ifdef SEQ_TIMEOUT_EN
  assign ERR           = err_q;
`else
  assign ERR           = 1'b0;
`endif
endmodule

// File: tb/tb_mvm_program_seq.sv
// Directed bench for mvm_program_seq with NUM_ROWS=4, DATAW=64.
module tb_mvm_program_seq;
  logic        clk, rst, start;
  logic [11:0] cfg_dest;
  logic [8:0]  cfg_rf, cfg_acc_addr, cfg_rls;
  logic        cfg_accum;
  logic        host_tvalid, host_tready;
  logic [63:0] host_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [11:0] m_tdest;
  logic [14:0] m_tuser;
  logic        r_tvalid, r_tready;
  logic [63:0] r_tdata;
  logic        busy, done, err;
  logic [63:0] result;

`ifdef SEQ_TIMEOUT_EN
  mvm_program_seq #(.DATAW(64), .DESTW(12), .NUM_ROWS(4), .RF_ADDRW(9), .TIMEOUT_CYC(100)) dut (
`else
  mvm_program_seq #(.DATAW(64), .DESTW(12), .NUM_ROWS(4), .RF_ADDRW(9)) dut (
`endif
    .CLK(clk), .RST(rst), .START(start),
    .CFG_DEST(cfg_dest), .CFG_RF_ADDR(cfg_rf), .CFG_ACCUM_ADDR(cfg_acc_addr),
    .CFG_RLS_DEST(cfg_rls), .CFG_ACCUM(cfg_accum),
    .HOST_TVALID(host_tvalid), .HOST_TREADY(host_tready), .HOST_TDATA(host_tdata),
    .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
    .AXIS_M_TDEST(m_tdest), .AXIS_M_TUSER(m_tuser), .AXIS_M_TLAST(m_tlast),
    .AXIS_R_TVALID(r_tvalid), .AXIS_R_TREADY(r_tready), .AXIS_R_TDATA(r_tdata),
    .BUSY(busy), .DONE(done), .ERR(err), .RESULT(result));

  typedef struct { logic [63:0] d; logic [14:0] u; logic [11:0] dst; logic l; } beat_t;
  beat_t q[$];

  logic [63:0] hwords [5] = '{64'h1111_0000_0000_00A0, 64'h2222_0000_0000_00A1,
                              64'h3333_0000_0000_00A2, 64'h4444_0000_0000_00A3,
                              64'h5555_0000_0000_00B0};
  logic [63:0] exp_d [6];
  logic [14:0] exp_u [6] = '{15'h0E01, 15'h1601, 15'h2601, 15'h4601, 15'h0400, 15'h0000};

  int total = 0, bad = 0, stab_bad = 0;
  int hidx = 0, hcnt = 0;
  logic rnd = 1'b0;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // Tile ready: constant high or ~30% random, changed just after each edge.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Host stream: hold word hidx while valid, advance after an accepting edge.
  initial begin
    logic acc;
    host_tvalid = 1'b0; host_tdata = '0;
    forever begin
      @(negedge clk);
      acc = host_tready && host_tvalid && !rst;
      @(posedge clk); #1;
      if (acc) hidx++;
      host_tvalid = (hidx < hcnt);
      host_tdata  = hwords[(hidx < 5) ? hidx : 0];
    end
  end

  // Beat monitor plus hold-under-backpressure check.
  initial begin
    logic  held;
    beat_t prev, cur;
    held = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{m_tdata, m_tuser, m_tdest, m_tlast};
      if (rst) held = 1'b0;
      else begin
        if (held && (!m_tvalid || cur.d !== prev.d || cur.u !== prev.u ||
                     cur.dst !== prev.dst || cur.l !== prev.l)) stab_bad++;
        if (m_tvalid && m_tready) q.push_back(cur);
        held = m_tvalid && !m_tready;
        prev = cur;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_prog();
    @(posedge clk); #3; hidx = 0; hcnt = 5;
    @(posedge clk); #3; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
  endtask

  task automatic wait_beats(int n, int lim);
    int c = 0;
    while (q.size() < n && c < lim) begin @(negedge clk); #1; c++; end
    chk("beat_count", 64'(q.size()), 64'(n));
  endtask

  task automatic wait_res(int lim);
    int c = 0;
    while (!r_tready && c < lim) begin @(negedge clk); c++; end
    chk("wait_res_reached", {63'd0, r_tready}, 64'd1);
  endtask

  task automatic check_beats(string tag);
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), q[i].d, exp_d[i]);
      chk($sformatf("%s_u%0d", tag, i), 64'(q[i].u), 64'(exp_u[i]));
      chk($sformatf("%s_dst%0d", tag, i), 64'(q[i].dst), 64'h001);
      chk($sformatf("%s_l%0d", tag, i), {63'd0, q[i].l}, 64'd1);
    end
  endtask

  task automatic deliver(logic [63:0] v, string tag);
    @(posedge clk); #3; r_tvalid = 1'b1; r_tdata = v;
    @(posedge clk); #3; r_tvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_result"}, result, v);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_tvalid"}, {63'd0, m_tvalid}, 64'd0);
    chk({tag, "_hready"}, {63'd0, host_tready}, 64'd0);
    chk({tag, "_rready"}, {63'd0, r_tready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_tdata"}, m_tdata, 64'd0);
    chk({tag, "_tuser"}, 64'(m_tuser), 64'd0);
    chk({tag, "_tdest"}, 64'(m_tdest), 64'd0);
    chk({tag, "_tlast"}, {63'd0, m_tlast}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_d[i] = hwords[i];
    exp_d[5] = 64'h0000_0000_80C0_201E;
    rst = 1'b1; start = 1'b0;
    cfg_dest = 12'h001; cfg_rf = 9'h001; cfg_acc_addr = 9'h001; cfg_rls = 9'h003; cfg_accum = 1'b1;
    r_tvalid = 1'b0; r_tdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #3; rst = 1'b0;

    // Program 1: full-rate, latency, beat contents, result capture.
    start_prog();
    @(negedge clk);
    chk("lat_tvalid_c1", {63'd0, m_tvalid}, 64'd0);
    chk("lat_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("lat_tvalid_c2", {63'd0, m_tvalid}, 64'd1);
    wait_beats(6, 200);
    check_beats("p1");
    wait_res(200);
    chk("p1_no_extra_beat", 64'(q.size()), 64'd6);
    deliver(64'hABCD, "p1");

    // Result offered in IDLE must not be taken.
    chk("idle_rready", {63'd0, r_tready}, 64'd0);
    @(posedge clk); #3; r_tvalid = 1'b1; r_tdata = 64'h1234;
    repeat (2) @(posedge clk);
    #3; r_tvalid = 1'b0;
    @(negedge clk);
    chk("idle_result_kept", result, 64'hABCD);
    chk("idle_no_done", {63'd0, done}, 64'd0);
    chk("idle_not_busy", {63'd0, busy}, 64'd0);

    // Program 2: random backpressure.
    q.delete(); rnd = 1'b1;
    start_prog();
    wait_beats(6, 3000);
    check_beats("p2");
    wait_res(3000);
    chk("p2_no_extra_beat", 64'(q.size()), 64'd6);
    chk("p2_hold_stable", 64'(stab_bad), 64'd0);
    rnd = 1'b0;
    deliver(64'h7777, "p2");

    // Program 3: reset during row 2, then replay from row 0.
    q.delete();
    start_prog();
    wait_beats(2, 200);
    #2; rst = 1'b1; #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #3; rst = 1'b0; q.delete();
    repeat (5) @(negedge clk);
    chk("postrst_no_beats", 64'(q.size()), 64'd0);
    chk("postrst_tvalid", {63'd0, m_tvalid}, 64'd0);
    start_prog();
    wait_beats(6, 200);
    check_beats("p3");
    wait_res(200);
    deliver(64'h5A5A, "p3");

`ifdef SEQ_TIMEOUT_EN
    // Program 4: no result; expect timeout after 100 WAIT_RES cycles.
    q.delete();
    start_prog();
    wait_beats(6, 200);
    wait_res(200);
    begin
      int n = 0;
      while (r_tready && n < 300) begin n++; @(negedge clk); end
      chk("to_wait_cycles", 64'(n), 64'd100);
    end
    chk("to_done", {63'd0, done}, 64'd1);
    chk("to_err", {63'd0, err}, 64'd1);
    chk("to_result_kept", result, 64'h5A5A);
    @(negedge clk);
    chk("to_done_pulse", {63'd0, done}, 64'd0);
    chk("to_err_sticky", {63'd0, err}, 64'd1);
`else
    chk("err_tied_low", {63'd0, err}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
